// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared button IDs and sizing defaults for the button front end
package btn_pkg;

   localparam int N_BTN_DEFAULT      = 5;
   localparam int ID_W_DEFAULT       = 3;
   localparam int FIFO_DEPTH_DEFAULT = 4;

   localparam logic [ID_W_DEFAULT-1:0] BTN_UP     = 3'd0;
   localparam logic [ID_W_DEFAULT-1:0] BTN_DOWN   = 3'd1;
   localparam logic [ID_W_DEFAULT-1:0] BTN_LEFT   = 3'd2;
   localparam logic [ID_W_DEFAULT-1:0] BTN_RIGHT  = 3'd3;
   localparam logic [ID_W_DEFAULT-1:0] BTN_CENTER = 3'd4;

   // Index reached by stepping 'step' places past 'last' around a ring of n buttons.
   function automatic int rr_index(input int last, input int step, input int n);
      return (last + step) % n;
   endfunction

endpackage

// File: rtl/evt_fifo.sv
// rtl/evt_fifo.sv - circular event queue with count/full/empty status
module evt_fifo #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/btn_event_arbiter.sv
// rtl/btn_event_arbiter.sv - latches button presses and round-robin queues them as IDs
module btn_event_arbiter
   import btn_pkg::*;
#(
   parameter int N_BTN      = N_BTN_DEFAULT,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
   parameter int ID_W       = ID_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_pulse,
   input  logic             evt_ready,
   input  logic             clr_ovf,
   output logic             evt_valid,
   output logic [ID_W-1:0]  evt_id,
   output logic [N_BTN-1:0] pending,
   output logic             ovf
);

   localparam int SEL_W = $clog2(N_BTN);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [ID_W-1:0]  rr_last;
   logic [ID_W-1:0]  winner;
   logic             found;
   logic             grant;
   logic [N_BTN-1:0] grant_vec;
   logic [N_BTN-1:0] coalesce;
   logic [ID_W-1:0]  head_id;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_full;
   logic             fifo_empty;
   logic             pop;

   // First pending bit after the last winner, wrapping around the ring.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      for (int k = 1; k <= N_BTN; k++) begin
         if (!found && pending[SEL_W'(rr_index(int'(rr_last), k, N_BTN))]) begin
            found  = 1'b1;
            winner = ID_W'(rr_index(int'(rr_last), k, N_BTN));
         end
      end
   end

   assign grant = found && !fifo_full;

   always_comb begin
      grant_vec = '0;
      for (int i = 0; i < N_BTN; i++)
         grant_vec[i] = grant && (winner == ID_W'(i));
   end

   // A press on a button whose earlier press is still waiting is merged into it.
   assign coalesce  = btn_pulse & pending & ~grant_vec;
   assign pop       = evt_valid && evt_ready;
   assign evt_valid = (fifo_count != '0);
   assign evt_id    = fifo_empty ? '0 : head_id;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= '0;
         ovf     <= 1'b0;
         rr_last <= ID_W'(N_BTN - 1);
      end else begin
         pending <= btn_pulse | (pending & ~grant_vec);
         ovf     <= (|coalesce) | (ovf & ~clr_ovf);
         if (grant)
            rr_last <= winner;
      end
   end

   evt_fifo #(
      .WIDTH (ID_W),
      .DEPTH (FIFO_DEPTH)
   ) u_evt_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (grant),
      .push_data (winner),
      .pop       (pop),
      .rd_data   (head_id),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule

// File: tb/tb_btn_event_arbiter.sv
// tb/tb_btn_event_arbiter.sv - directed self-checking bench for btn_event_arbiter
module tb_btn_event_arbiter;

   logic       clk;
   logic       rst;
   logic [4:0] btn_pulse;
   logic       evt_ready;
   logic       clr_ovf;
   logic       evt_valid;
   logic [2:0] evt_id;
   logic [4:0] pending;
   logic       ovf;

   int checks = 0;
   int errors = 0;

   btn_event_arbiter #(
      .N_BTN      (5),
      .FIFO_DEPTH (4),
      .ID_W       (3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_pulse (btn_pulse),
      .evt_ready (evt_ready),
      .clr_ovf   (clr_ovf),
      .evt_valid (evt_valid),
      .evt_id    (evt_id),
      .pending   (pending),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      btn_pulse = '0;
      evt_ready = 1'b0;
      clr_ovf   = 1'b0;
      rst       = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (evt_valid !== 1'b0 || pending !== 5'b0 || ovf !== 1'b0 || evt_id !== 3'd0) begin
         errors++;
         $display("FAIL reset_state: got valid=%b pending=%b ovf=%b id=%0d expected 0 0 0 0",
                  evt_valid, pending, ovf, evt_id);
      end
      btn_pulse = 5'b00111; tick();
      btn_pulse = 5'b00100; tick();
      btn_pulse = 5'b00000; tick();
      btn_pulse = 5'b10000; tick();
      btn_pulse = 5'b00000;
      checks++;
      if (pending !== 5'b10000 || ovf !== 1'b1 || evt_valid !== 1'b1 || evt_id !== 3'd0) begin
         errors++;
         $display("FAIL pre_reset_state: got pending=%b ovf=%b valid=%b id=%0d expected 10000 1 1 0",
                  pending, ovf, evt_valid, evt_id);
      end
      #1 rst = 1'b1;
      #1;
      checks++;
      if (evt_valid !== 1'b0 || pending !== 5'b0 || ovf !== 1'b0 || evt_id !== 3'd0) begin
         errors++;
         $display("FAIL midstream_reset: got valid=%b pending=%b ovf=%b id=%0d expected 0 0 0 0",
                  evt_valid, pending, ovf, evt_id);
      end
      tick();
      tick();
      rst       = 1'b0;
      evt_ready = 1'b1;
      btn_pulse = 5'b00100; tick();
      btn_pulse = 5'b00000;
      checks++;
      if (evt_valid !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_t1_valid: got %b expected 0", evt_valid);
      end
      tick();
      checks++;
      if (evt_valid !== 1'b1 || evt_id !== 3'd2) begin
         errors++;
         $display("FAIL post_reset_t2_event: got valid=%b id=%0d expected 1 2", evt_valid, evt_id);
      end
   endtask

   task automatic test_simultaneous();
      logic [2:0] exp_seq [3];
      exp_seq = '{3'd0, 3'd2, 3'd4};
      do_reset();
      evt_ready = 1'b1;
      btn_pulse = 5'b10101; tick();
      btn_pulse = 5'b00000; tick();
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (evt_valid !== 1'b1 || evt_id !== exp_seq[k]) begin
            errors++;
            $display("FAIL simultaneous_seq[%0d]: got valid=%b id=%0d expected 1 %0d",
                     k, evt_valid, evt_id, exp_seq[k]);
         end
         tick();
      end
      checks++;
      if (evt_valid !== 1'b0) begin
         errors++;
         $display("FAIL simultaneous_drain: got valid=%b expected 0", evt_valid);
      end
   endtask

   task automatic test_fairness();
      logic [2:0] exp_id;
      do_reset();
      evt_ready = 1'b1;
      btn_pulse = 5'b00011;
      for (int k = 1; k <= 9; k++) begin
         tick();
         if (k >= 2) begin
            exp_id = (k % 2 == 0) ? 3'd0 : 3'd1;
            checks++;
            if (evt_valid !== 1'b1 || evt_id !== exp_id) begin
               errors++;
               $display("FAIL fairness_grant[%0d]: got valid=%b id=%0d expected 1 %0d",
                        k - 1, evt_valid, evt_id, exp_id);
            end
         end
         if (k <= 7)
            btn_pulse = (k % 2 == 1) ? 5'b00001 : 5'b00010;
         else
            btn_pulse = 5'b00000;
      end
      checks++;
      if (ovf !== 1'b0) begin
         errors++;
         $display("FAIL fairness_ovf: got %b expected 0", ovf);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int k = 0; k < 5; k++) begin
         btn_pulse = 5'b00001 << k;
         tick();
      end
      btn_pulse = 5'b00000;
      tick();
      checks++;
      if (pending !== 5'b10000 || evt_valid !== 1'b1 || evt_id !== 3'd0 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL backpressure_full: got pending=%b valid=%b id=%0d ovf=%b expected 10000 1 0 0",
                  pending, evt_valid, evt_id, ovf);
      end
      evt_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (evt_valid !== 1'b1 || evt_id !== 3'(k)) begin
            errors++;
            $display("FAIL backpressure_drain[%0d]: got valid=%b id=%0d expected 1 %0d",
                     k, evt_valid, evt_id, k);
         end
         tick();
      end
      checks++;
      if (evt_valid !== 1'b0 || ovf !== 1'b0 || pending !== 5'b0) begin
         errors++;
         $display("FAIL backpressure_empty: got valid=%b ovf=%b pending=%b expected 0 0 00000",
                  evt_valid, ovf, pending);
      end
   endtask

   task automatic test_coalesce();
      do_reset();
      btn_pulse = 5'b01111; tick();
      btn_pulse = 5'b00000;
      for (int k = 0; k < 4; k++)
         tick();
      btn_pulse = 5'b10000; tick();
      checks++;
      if (pending !== 5'b10000 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL coalesce_first: got pending=%b ovf=%b expected 10000 0", pending, ovf);
      end
      btn_pulse = 5'b10000; tick();
      btn_pulse = 5'b00000;
      checks++;
      if (pending !== 5'b10000 || ovf !== 1'b1) begin
         errors++;
         $display("FAIL coalesce_second: got pending=%b ovf=%b expected 10000 1", pending, ovf);
      end
      clr_ovf = 1'b1; tick();
      clr_ovf = 1'b0;
      checks++;
      if (ovf !== 1'b0) begin
         errors++;
         $display("FAIL coalesce_clear: got ovf=%b expected 0", ovf);
      end
      btn_pulse = 5'b10000;
      clr_ovf   = 1'b1;
      tick();
      btn_pulse = 5'b00000;
      clr_ovf   = 1'b0;
      checks++;
      if (ovf !== 1'b1) begin
         errors++;
         $display("FAIL coalesce_set_beats_clear: got ovf=%b expected 1", ovf);
      end
      clr_ovf = 1'b1; tick();
      clr_ovf = 1'b0;
      checks++;
      if (ovf !== 1'b0) begin
         errors++;
         $display("FAIL coalesce_reclear: got ovf=%b expected 0", ovf);
      end
   endtask

   task automatic test_stability();
      evt_ready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         checks++;
         if (evt_valid !== 1'b1 || evt_id !== 3'd0 || pending !== 5'b10000) begin
            errors++;
            $display("FAIL stability[%0d]: got valid=%b id=%0d pending=%b expected 1 0 10000",
                     k, evt_valid, evt_id, pending);
         end
         tick();
      end
      evt_ready = 1'b1; tick();
      evt_ready = 1'b0;
      checks++;
      if (evt_valid !== 1'b1 || evt_id !== 3'd1) begin
         errors++;
         $display("FAIL stability_release: got valid=%b id=%0d expected 1 1", evt_valid, evt_id);
      end
   endtask

   initial begin
      rst       = 1'b1;
      btn_pulse = '0;
      evt_ready = 1'b0;
      clr_ovf   = 1'b0;
      test_reset();
      test_simultaneous();
      test_fairness();
      test_backpressure();
      test_coalesce();
      test_stability();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
